// File: rtl/misc_branch_pipe.sv
// Misc-ops execution branch (move/shift/abs/clamp, optional DATA_W saturation) with a
// STAGES-deep valid/ready pipeline; latency STAGES cycles, bubbles collapse, enable=0 freezes all.
module misc_branch_pipe #(
    parameter int DATA_W   = 16,
    parameter int N_BLOCKS = 256,
    parameter int STAGES   = 2,
    parameter int SHIFT_W  = 5,
    parameter int CNT_W    = 16
) (
    input  logic                              clk,
    input  logic                              reset,
    input  logic                              enable,
    input  logic                              in_valid,
    output logic                              in_ready,
    output logic                              out_valid,
    input  logic                              out_ready,
    input  logic [$clog2(N_BLOCKS)-1:0]       block_in,
    output logic [$clog2(N_BLOCKS)-1:0]       block_out,
    input  logic signed [DATA_W-1:0]          arg_a_in,
    input  logic signed [DATA_W-1:0]          arg_b_in,
    input  logic signed [DATA_W-1:0]          arg_c_in,
    input  logic signed [2*DATA_W-1:0]        accumulator_in,
    input  logic [4:0]                        operation_in,
    input  logic                              saturate_disable_in,
    input  logic [SHIFT_W-1:0]                shift_in,
    input  logic [3:0]                        dest_in,
    output logic [3:0]                        dest_out,
    output logic signed [2*DATA_W-1:0]        result_out,
    input  logic [8:0]                        commit_id_in,
    output logic [8:0]                        commit_id_out,
    input  logic                              commit_flag_in,
    output logic                              commit_flag_out,
    output logic                              sat_out,
    output logic [CNT_W-1:0]                  sat_count,
    input  logic                              sat_count_clear
);

    localparam int RW    = 2 * DATA_W;
    localparam int BLK_W = $clog2(N_BLOCKS);

    localparam logic [4:0] OP_MOV_ACC  = 5'd0;
    localparam logic [4:0] OP_ABS      = 5'd1;
    localparam logic [4:0] OP_CLAMP    = 5'd2;
    localparam logic [4:0] OP_LSH      = 5'd3;
    localparam logic [4:0] OP_RSH      = 5'd4;
    localparam logic [4:0] OP_MOV_UACC = 5'd5;
    localparam logic [4:0] OP_MOV_LACC = 5'd6;

    localparam logic signed [RW-1:0] SAT_MAX = {{(DATA_W+1){1'b0}}, {(DATA_W-1){1'b1}}};
    localparam logic signed [RW-1:0] SAT_MIN = {{(DATA_W+1){1'b1}}, {(DATA_W-1){1'b0}}};

    typedef struct packed {
        logic [BLK_W-1:0] blk;
        logic [3:0]       dest;
        logic [8:0]       cid;
        logic             cflag;
        logic [RW-1:0]    result;
        logic             sat;
    } stage_t;

    stage_t              pipe [STAGES];
    stage_t              comp;
    logic [STAGES-1:0]   vld;
    logic [STAGES:0]     rdy;
    logic                chain;

    logic signed [RW-1:0] a_ext, b_ext, c_ext, lo_b, hi_b, acc_sh, raw, clipped;
    logic                 over;
    logic                 sat_event;

    // Stage 0 datapath: everything is evaluated at 2*DATA_W so ABS(min) cannot wrap.
    always_comb begin
        a_ext  = {{DATA_W{arg_a_in[DATA_W-1]}}, arg_a_in};
        b_ext  = {{DATA_W{arg_b_in[DATA_W-1]}}, arg_b_in};
        c_ext  = {{DATA_W{arg_c_in[DATA_W-1]}}, arg_c_in};
        lo_b   = (b_ext < c_ext) ? b_ext : c_ext;
        hi_b   = (b_ext < c_ext) ? c_ext : b_ext;
        over   = (int'(shift_in) >= RW);
        acc_sh = accumulator_in >>> shift_in;
        case (operation_in)
            OP_MOV_ACC:  raw = over ? {RW{accumulator_in[RW-1]}} : acc_sh;
            OP_ABS:      raw = a_ext[RW-1] ? -a_ext : a_ext;
            OP_CLAMP:    raw = (a_ext < lo_b) ? lo_b : ((a_ext > hi_b) ? hi_b : a_ext);
            OP_LSH:      raw = over ? '0 : (a_ext << shift_in);
            OP_RSH:      raw = over ? '0 : ({{DATA_W{1'b0}}, arg_a_in} >> shift_in);
            OP_MOV_UACC: raw = {{DATA_W{1'b0}}, accumulator_in[RW-1:DATA_W]};
            OP_MOV_LACC: raw = {{DATA_W{1'b0}}, accumulator_in[DATA_W-1:0]};
            default:     raw = '0;
        endcase
        clipped = (raw > SAT_MAX) ? SAT_MAX : ((raw < SAT_MIN) ? SAT_MIN : raw);

        comp.blk    = block_in;
        comp.dest   = dest_in;
        comp.cid    = commit_id_in;
        comp.cflag  = commit_flag_in;
        comp.result = saturate_disable_in ? raw : clipped;
        comp.sat    = ~saturate_disable_in & (clipped != raw);
    end

    // A stage can take new data if it is empty or everything downstream of it moves.
    always_comb begin
        chain       = out_ready;
        rdy[STAGES] = out_ready;
        for (int k = STAGES - 1; k >= 0; k--) begin
            chain  = ~vld[k] | chain;
            rdy[k] = chain;
        end
    end

    assign in_ready        = enable & rdy[0];
    assign out_valid       = vld[STAGES-1];
    assign block_out       = pipe[STAGES-1].blk;
    assign dest_out        = pipe[STAGES-1].dest;
    assign commit_id_out   = pipe[STAGES-1].cid;
    assign commit_flag_out = pipe[STAGES-1].cflag;
    assign result_out      = pipe[STAGES-1].result;
    assign sat_out         = pipe[STAGES-1].sat;
    assign sat_event       = out_valid & out_ready & pipe[STAGES-1].sat;

    always_ff @(posedge clk) begin
        if (reset) begin
            vld       <= '0;
            sat_count <= '0;
            for (int k = 0; k < STAGES; k++) begin
                pipe[k] <= '0;
            end
        end else if (enable) begin
            if (rdy[0]) begin
                vld[0] <= in_valid;
                if (in_valid) begin
                    pipe[0] <= comp;
                end
            end
            for (int k = 1; k < STAGES; k++) begin
                if (rdy[k]) begin
                    vld[k] <= vld[k-1];
                    if (vld[k-1]) begin
                        pipe[k] <= pipe[k-1];
                    end
                end
            end
            if (sat_count_clear) begin
                sat_count <= sat_event ? CNT_W'(1) : '0;
            end else if (sat_event && !(&sat_count)) begin
                sat_count <= sat_count + CNT_W'(1);
            end
        end
    end

endmodule
